// File: rtl/ysyx_22040750_pipe_pkg.sv
// Shared constants for the fullpipeline stage registers: bubble instruction,
// field widths and sizing helpers for occupancy counters and buffer pointers.
package ysyx_22040750_pipe_pkg;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam int          INST_W   = 32;
  localparam int          PC_W     = 32;

  // Width needed to hold an occupancy of 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; a single-entry buffer still needs one bit to index.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ysyx_22040750_pipe_buf.sv
// DEPTH x (DATA_W+1) storage for the stage register: payload plus bubble flag,
// one write port and an asynchronous read of the head entry.
module ysyx_22040750_pipe_buf
  import ysyx_22040750_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = ptr_w(DEPTH)
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_bub,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_bub
);

  // Bit DATA_W of each entry is the bubble flag.
  logic [DEPTH-1:0][DATA_W:0] mem;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[wr_idx] <= {wr_bub, wr_data};
    end
  end

  assign rd_data = mem[rd_idx][DATA_W-1:0];
  assign rd_bub  = mem[rd_idx][DATA_W];

endmodule

// File: rtl/ysyx_22040750_pipe_skid_reg.sv
// Parametrised pipeline-stage register: DEPTH-entry circular buffer with
// valid/allowin/allowout handshake, stall, flush and jump-bubble injection.
// Optional PIPE_STAT_EN adds stall-cycle and bubble-injection counters.
module ysyx_22040750_pipe_skid_reg
  import ysyx_22040750_pipe_pkg::*;
#(
  parameter int          DATA_W  = 64,
  parameter int          DEPTH   = 2,
  parameter int          NOP_LSB = 0,
  parameter logic [31:0] NOP_VAL = NOP_INST
) (
  input  logic                         I_sys_clk,
  input  logic                         I_rst_n,
  input  logic                         I_valid,
  input  logic [DATA_W-1:0]            I_data,
  input  logic                         I_jmp,
  input  logic                         I_flush,
  input  logic                         I_stall,
  input  logic                         I_allowout,
  output logic                         O_allowin,
  output logic                         O_valid,
  output logic [DATA_W-1:0]            O_data,
  output logic                         O_bubble,
  output logic                         O_input_valid,
  output logic [$clog2(DEPTH+1)-1:0]   O_count,
  output logic [31:0]                  O_stall_cnt,
  output logic [31:0]                  O_bubble_cnt
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);

  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [DATA_W-1:0] wdata;
  logic              push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign O_input_valid = (cnt != '0);
  assign O_valid       = O_input_valid && !I_stall;
  assign pop           = O_valid && I_allowout;
  assign O_count       = cnt;

  // Deeper buffers decide allowin from registered state only, cutting the
  // combinational ready chain; a single entry must pass pop through.
  generate
    if (DEPTH == 1) begin : g_allow_comb
      assign O_allowin = (cnt == '0) || pop;
    end else begin : g_allow_reg
      assign O_allowin = (cnt < CNT_W'(DEPTH));
    end
  endgenerate

  assign push = I_valid && O_allowin && !I_flush;

  always_comb begin
    wdata = I_data;
    if (I_jmp) wdata[NOP_LSB +: INST_W] = NOP_VAL;
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (I_flush) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  ysyx_22040750_pipe_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_buf (
    .gclk    (I_sys_clk),
    .grst_n  (I_rst_n),
    .we      (push),
    .wr_idx  (wr_ptr),
    .wr_data (wdata),
    .wr_bub  (I_jmp),
    .rd_idx  (rd_ptr),
    .rd_data (O_data),
    .rd_bub  (O_bubble)
  );

`ifdef PIPE_STAT_EN
  logic [31:0] stall_cnt, bubble_cnt;

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (I_stall && O_input_valid) stall_cnt  <= stall_cnt + 32'd1;
      if (push && I_jmp)            bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign O_stall_cnt  = stall_cnt;
  assign O_bubble_cnt = bubble_cnt;
`else
  assign O_stall_cnt  = '0;
  assign O_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040750_pipe_skid_reg.sv
// Directed bench for the stage register: DEPTH=2 main instance plus a DEPTH=1
// instance for the combinational allowin path.
module tb_ysyx_22040750_pipe_skid_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=2 instance signals
  logic        valid, jmp, flush, stall, allowout;
  logic [63:0] data;
  logic        allowin, o_valid, bubble, input_valid;
  logic [63:0] o_data;
  logic [1:0]  count;
  logic [31:0] stall_cnt, bubble_cnt;

  // DEPTH=1 instance signals
  logic        valid1, jmp1, flush1, stall1, allowout1;
  logic [63:0] data1;
  logic        allowin1, o_valid1, bubble1, input_valid1;
  logic [63:0] o_data1;
  logic [0:0]  count1;
  logic [31:0] stall_cnt1, bubble_cnt1;

  int n_chk = 0;
  int n_err = 0;

  ysyx_22040750_pipe_skid_reg #(.DATA_W(64), .DEPTH(2)) u_dut (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_valid(valid), .I_data(data),
    .I_jmp(jmp), .I_flush(flush), .I_stall(stall), .I_allowout(allowout),
    .O_allowin(allowin), .O_valid(o_valid), .O_data(o_data),
    .O_bubble(bubble), .O_input_valid(input_valid), .O_count(count),
    .O_stall_cnt(stall_cnt), .O_bubble_cnt(bubble_cnt)
  );

  ysyx_22040750_pipe_skid_reg #(.DATA_W(64), .DEPTH(1)) u_dut1 (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_valid(valid1), .I_data(data1),
    .I_jmp(jmp1), .I_flush(flush1), .I_stall(stall1), .I_allowout(allowout1),
    .O_allowin(allowin1), .O_valid(o_valid1), .O_data(o_data1),
    .O_bubble(bubble1), .O_input_valid(input_valid1), .O_count(count1),
    .O_stall_cnt(stall_cnt1), .O_bubble_cnt(bubble_cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] beat [4];
  logic [31:0] exp_bub_cnt;
  logic [31:0] exp_stall_cnt;

  initial begin
    {valid, jmp, flush, stall, allowout} = '0;
    {valid1, jmp1, flush1, stall1, allowout1} = '0;
    data = '0;
    data1 = '0;
`ifdef PIPE_STAT_EN
    exp_bub_cnt   = 32'd1;
    exp_stall_cnt = 32'd3;
`else
    exp_bub_cnt   = 32'd0;
    exp_stall_cnt = 32'd0;
`endif

    // Reset state
    #12;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ivalid", 64'(input_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_data", o_data, 64'd0);
    chk("rst_bubble", 64'(bubble), 64'd0);
    chk("rst_allowin", 64'(allowin), 64'd1);
    chk("rst_stallcnt", 64'(stall_cnt), 64'd0);
    chk("rst_bubcnt", 64'(bubble_cnt), 64'd0);
    chk("rst1_count", 64'(count1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: one beat in, one beat out each cycle
    for (int i = 0; i < 4; i++)
      beat[i] = {32'h80000000 + 32'(4 * i), 32'h00500093 + 32'(i << 20)};
    step();
    allowout = 1'b1;
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data = beat[i];
      step();
      chk("str_valid", 64'(o_valid), 64'd1);
      chk("str_data", o_data, beat[i]);
      chk("str_count", 64'(count), 64'd1);
      chk("str_allowin", 64'(allowin), 64'd1);
    end
    valid = 1'b0;
    step();
    chk("str_drain_cnt", 64'(count), 64'd0);
    chk("str_drain_vld", 64'(o_valid), 64'd0);

    // Backpressure: fill both entries, third beat held upstream
    allowout = 1'b0;
    valid = 1'b1;
    data = 64'hA;
    step();
    chk("bp_cnt1", 64'(count), 64'd1);
    data = 64'hB;
    step();
    chk("bp_cnt2", 64'(count), 64'd2);
    chk("bp_allowin", 64'(allowin), 64'd0);
    chk("bp_head", o_data, 64'hA);
    data = 64'hC;
    step();
    chk("bp_hold_cnt", 64'(count), 64'd2);
    chk("bp_hold_data", o_data, 64'hA);
    allowout = 1'b1;
    #1;
    chk("bp_allowin_reg", 64'(allowin), 64'd0);
    step();
    chk("bp_drain_b", o_data, 64'hB);
    chk("bp_drain_cnt", 64'(count), 64'd1);
    step();
    chk("bp_drain_c", o_data, 64'hC);
    chk("bp_drain_cnt2", 64'(count), 64'd1);
    valid = 1'b0;
    step();
    chk("bp_empty", 64'(count), 64'd0);

    // Jump bubble injection
    allowout = 1'b0;
    valid = 1'b1;
    jmp = 1'b1;
    data = {32'h80000100, 32'h0000006f};
    step();
    chk("jmp_data", o_data, {32'h80000100, 32'h00000013});
    chk("jmp_bubble", 64'(bubble), 64'd1);
    chk("jmp_bubcnt", 64'(bubble_cnt), 64'(exp_bub_cnt));
    jmp = 1'b0;
    valid = 1'b0;
    allowout = 1'b1;
    step();
    chk("jmp_pop", 64'(count), 64'd0);

    // Flush with a same-cycle incoming beat
    allowout = 1'b0;
    valid = 1'b1;
    data = 64'h1111;
    step();
    data = 64'h2222;
    step();
    chk("fl_full", 64'(count), 64'd2);
    flush = 1'b1;
    data = 64'h3333;
    step();
    chk("fl_cnt", 64'(count), 64'd0);
    chk("fl_vld", 64'(o_valid), 64'd0);
    flush = 1'b0;
    valid = 1'b0;
    allowout = 1'b1;
    step();
    chk("fl_cnt2", 64'(count), 64'd0);
    chk("fl_vld2", 64'(o_valid), 64'd0);
    chk("fl_bubcnt", 64'(bubble_cnt), 64'(exp_bub_cnt));

    // Stall for three cycles with one beat buffered
    allowout = 1'b0;
    valid = 1'b1;
    data = 64'h5555;
    step();
    valid = 1'b0;
    allowout = 1'b1;
    stall = 1'b1;
    #1;
    chk("st_vld", 64'(o_valid), 64'd0);
    chk("st_ivld", 64'(input_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_cnt", 64'(count), 64'd1);
      chk("st_vld_hold", 64'(o_valid), 64'd0);
    end
    chk("st_stallcnt", 64'(stall_cnt), 64'(exp_stall_cnt));
    stall = 1'b0;
    #1;
    chk("st_rel_vld", 64'(o_valid), 64'd1);
    chk("st_rel_data", o_data, 64'h5555);
    step();
    chk("st_rel_cnt", 64'(count), 64'd0);

    // DEPTH=1: full, simultaneous pop and push
    valid1 = 1'b1;
    data1 = 64'h7777;
    step();
    chk("d1_cnt", 64'(count1), 64'd1);
    chk("d1_allowin_full", 64'(allowin1), 64'd0);
    allowout1 = 1'b1;
    data1 = 64'h8888;
    #1;
    chk("d1_allowin_pass", 64'(allowin1), 64'd1);
    step();
    chk("d1_cnt_same", 64'(count1), 64'd1);
    chk("d1_data", o_data1, 64'h8888);
    valid1 = 1'b0;
    step();
    chk("d1_empty", 64'(count1), 64'd0);

    // Asynchronous reset mid-cycle
    allowout = 1'b0;
    valid = 1'b1;
    data = 64'h9999;
    step();
    chk("ar_pre_vld", 64'(o_valid), 64'd1);
    valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", 64'(o_valid), 64'd0);
    chk("ar_cnt", 64'(count), 64'd0);
    chk("ar_data", o_data, 64'd0);
    chk("ar_stallcnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_post_cnt", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
